// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared constants and types for the buffered SPI master.
//   - register word offsets on the CPU I/O window
//   - CTRL register bit positions
//   - shifter FSM state type
//   - default FIFO depth
package spi_master_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;

  localparam int CTRL_CS       = 0;
  localparam int CTRL_BUSY     = 1;
  localparam int CTRL_TX_FULL  = 2;
  localparam int CTRL_RX_EMPTY = 3;
  localparam int CTRL_TX_OVF   = 4;
  localparam int CTRL_TX_CNT   = 8;
  localparam int CTRL_RX_CNT   = 12;

  localparam int DEFAULT_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } shift_state_t;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: MicroBlaze I/O bus slice seen by the SPI master.
//   master modport: CPU side (drives select, strobes, address, write data)
//   slave modport : peripheral side (returns registered read data and ready)
interface spi_master_if;
  logic        io_sel;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [1:0]  io_addr;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  modport master (
    output io_sel, io_addr_strobe, io_read_strobe, io_write_strobe,
    output io_addr, io_write_data,
    input  io_read_data, io_ready
  );

  modport slave (
    input  io_sel, io_addr_strobe, io_read_strobe, io_write_strobe,
    input  io_addr, io_write_data,
    output io_read_data, io_ready
  );
endinterface

// File: rtl/spi_fifo.sv
// spi_fifo: synchronous FIFO with first-word-fall-through output.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data (accepted when full if a pop
//                   happens in the same cycle)
//   pop, dout     : read request and current head entry
//   full, empty   : status flags
//   count         : number of stored entries
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: buffered SPI master (mode 3) on the MicroBlaze I/O bus.
//   clk_48, rst : system clock, asynchronous active-high reset
//   io          : I/O bus slave (CTRL/DATA/DIV registers, registered reads,
//                 one-cycle io_ready)
//   spi_cs      : chip select, active-low, firmware controlled
//   spi_clk     : SPI clock, idles high, half-period DIV+1 cycles
//   spi_mosi    : serial out, MSB first
//   spi_miso    : serial in, sampled on the rising spi_clk
// Build option SPI_MASTER_RX_FIFO_EN: received bytes go into an RX FIFO and
// the shifter stalls while it is full. Without it a single holding register
// is overwritten at every byte end and DATA reads do not pop.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DIV_W      = 8
) (
  input  logic       clk_48,
  input  logic       rst,
  spi_master_if.slave io,
  output logic       spi_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic acc, wr, rd, wr_ctrl, wr_data, wr_div;
  assign acc     = io.io_addr_strobe && io.io_sel;
  assign wr      = acc && io.io_write_strobe;
  assign rd      = acc && io.io_read_strobe;
  assign wr_ctrl = wr && (io.io_addr == ADDR_CTRL);
  assign wr_data = wr && (io.io_addr == ADDR_DATA);
  assign wr_div  = wr && (io.io_addr == ADDR_DIV);

  logic unused_bits;
  assign unused_bits = ^io.io_write_data[31:8];

  logic             cs_reg, tx_ovf;
  logic [DIV_W-1:0] div_reg, div_lat, hp_cnt;
  shift_state_t     state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg, rx_byte;
  logic             hp_done, start_ok, load_byte, rx_push, rx_ok;

  logic             tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_dout;
  logic [CNT_W-1:0] tx_count;

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_48), .rst(rst),
    .push(wr_data), .pop(tx_pop), .din(io.io_write_data[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  logic       rx_empty_bit;
  logic [3:0] rx_count_fld;
  logic [7:0] data_rd;

`ifdef SPI_MASTER_RX_FIFO_EN
  logic             rx_full, rx_empty;
  logic [7:0]       rx_dout;
  logic [CNT_W-1:0] rx_count;

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_48), .rst(rst),
    .push(rx_push), .pop(rd && (io.io_addr == ADDR_DATA)), .din(rx_byte),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign rx_ok        = !rx_full;
  assign rx_empty_bit = rx_empty;
  assign rx_count_fld = 4'(rx_count);
  assign data_rd      = rx_empty ? 8'h00 : rx_dout;
`else
  logic [7:0] rx_hold;

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst)          rx_hold <= '0;
    else if (rx_push) rx_hold <= rx_byte;
  end

  assign rx_ok        = 1'b1;
  assign rx_empty_bit = 1'b0;
  assign rx_count_fld = 4'd0;
  assign data_rd      = rx_hold;
`endif

  assign hp_done   = (hp_cnt == '0);
  assign start_ok  = !tx_empty && rx_ok;
  assign load_byte = start_ok &&
                     ((state == ST_IDLE) ||
                      (state == ST_HIGH && hp_done && bit_cnt == 4'd0));
  assign tx_pop    = load_byte;
  // The byte is complete at the 8th rising edge; pushing it there makes it
  // readable while spi_clk is still high instead of a half-period later.
  assign rx_push   = (state == ST_LOW) && hp_done && (bit_cnt == 4'd1);
  assign rx_byte   = {shreg[6:0], spi_miso};

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      spi_clk  <= 1'b1;
      spi_mosi <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      hp_cnt   <= '0;
      div_lat  <= '0;
    end else if (load_byte) begin
      state    <= ST_LOW;
      spi_clk  <= 1'b0;
      spi_mosi <= tx_dout[7];
      shreg    <= tx_dout;
      bit_cnt  <= 4'd8;
      div_lat  <= div_reg;
      hp_cnt   <= div_reg;
    end else begin
      case (state)
        ST_LOW: begin
          if (hp_done) begin
            state   <= ST_HIGH;
            spi_clk <= 1'b1;
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt - 4'd1;
            hp_cnt  <= div_lat;
          end else begin
            hp_cnt <= hp_cnt - DIV_W'(1);
          end
        end
        ST_HIGH: begin
          if (!hp_done) begin
            hp_cnt <= hp_cnt - DIV_W'(1);
          end else if (bit_cnt != 4'd0) begin
            state    <= ST_LOW;
            spi_clk  <= 1'b0;
            spi_mosi <= shreg[7];
            hp_cnt   <= div_lat;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (io.io_addr)
      ADDR_CTRL: begin
        rdata[CTRL_CS]          = cs_reg;
        rdata[CTRL_BUSY]        = (state != ST_IDLE) || !tx_empty;
        rdata[CTRL_TX_FULL]     = tx_full;
        rdata[CTRL_RX_EMPTY]    = rx_empty_bit;
        rdata[CTRL_TX_OVF]      = tx_ovf;
        rdata[CTRL_TX_CNT +: 4] = 4'(tx_count);
        rdata[CTRL_RX_CNT +: 4] = rx_count_fld;
      end
      ADDR_DATA: rdata = {24'h0, data_rd};
      ADDR_DIV:  rdata = 32'(div_reg);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      cs_reg          <= 1'b1;
      tx_ovf          <= 1'b0;
      div_reg         <= '0;
      io.io_ready     <= 1'b0;
      io.io_read_data <= '0;
    end else begin
      io.io_ready <= acc && (io.io_read_strobe || io.io_write_strobe);
      if (rd) io.io_read_data <= rdata;
      if (wr_ctrl) cs_reg <= io.io_write_data[CTRL_CS];
      if (wr_div) div_reg <= io.io_write_data[DIV_W-1:0];
      // A push into a full FIFO survives only when the shifter pops that cycle.
      if (wr_data && tx_full && !tx_pop)
        tx_ovf <= 1'b1;
      else if (wr_ctrl && io.io_write_data[CTRL_TX_OVF])
        tx_ovf <= 1'b0;
    end
  end

  assign spi_cs = cs_reg;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  import spi_master_pkg::*;

  logic clk_48 = 1'b0;
  logic rst;
  logic spi_cs, spi_clk, spi_mosi, spi_miso;
  logic miso_hi;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int rise_q[$];
  int fall_q[$];
  logic mosi_q[$];
  logic prev_clk = 1'b1;
  logic [31:0] r;
  logic [7:0] mb;
  int t0;

`ifdef SPI_MASTER_RX_FIFO_EN
  localparam logic [31:0] RXE = 32'h0000_0008;
`else
  localparam logic [31:0] RXE = 32'h0000_0000;
`endif

  typedef struct {
    logic [7:0] div;
    logic [7:0] tx;
    logic       miso_hi;
    logic [7:0] exp_rx;
    int         period;
  } vec_t;

  vec_t vecs[5];

  spi_master_if bus();

  spi_master #(.FIFO_DEPTH(8), .DIV_W(8)) dut (
    .clk_48  (clk_48),
    .rst     (rst),
    .io      (bus),
    .spi_cs  (spi_cs),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk_48 = ~clk_48;

  assign spi_miso = miso_hi ? 1'b1 : spi_mosi;

  always @(posedge clk_48) cyc <= cyc + 1;

  always begin
    @(posedge clk_48);
    #1;
    if (spi_clk && !prev_clk) begin
      rise_q.push_back(cyc);
      mosi_q.push_back(spi_mosi);
    end
    if (!spi_clk && prev_clk) fall_q.push_back(cyc);
    prev_clk = spi_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk_48); #1;
    bus.io_sel = 1'b1; bus.io_addr_strobe = 1'b1; bus.io_write_strobe = 1'b1;
    bus.io_addr = a; bus.io_write_data = d;
    last_wr_cyc = cyc;
    @(posedge clk_48); #1;
    bus.io_sel = 1'b0; bus.io_addr_strobe = 1'b0; bus.io_write_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk_48); #1;
    bus.io_sel = 1'b1; bus.io_addr_strobe = 1'b1; bus.io_read_strobe = 1'b1;
    bus.io_addr = a;
    @(posedge clk_48); #1;
    bus.io_sel = 1'b0; bus.io_addr_strobe = 1'b0; bus.io_read_strobe = 1'b0;
    d = bus.io_read_data;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_read(ADDR_CTRL, s);
      n++;
    end while (s[CTRL_BUSY] && n < 4000);
    check(name, 32'(s[CTRL_BUSY]), 32'd0);
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    mosi_q.delete();
  endtask

  initial begin
    vecs[0] = '{div: 8'd0, tx: 8'hA5, miso_hi: 1'b0, exp_rx: 8'hA5, period: 2};
    vecs[1] = '{div: 8'd1, tx: 8'h3C, miso_hi: 1'b0, exp_rx: 8'h3C, period: 4};
    vecs[2] = '{div: 8'd2, tx: 8'h00, miso_hi: 1'b1, exp_rx: 8'hFF, period: 6};
    vecs[3] = '{div: 8'd0, tx: 8'hFF, miso_hi: 1'b0, exp_rx: 8'hFF, period: 2};
    vecs[4] = '{div: 8'd3, tx: 8'h81, miso_hi: 1'b0, exp_rx: 8'h81, period: 8};

    rst = 1'b1;
    miso_hi = 1'b0;
    bus.io_sel = 1'b0; bus.io_addr_strobe = 1'b0;
    bus.io_read_strobe = 1'b0; bus.io_write_strobe = 1'b0;
    bus.io_addr = 2'd0; bus.io_write_data = 32'd0;
    repeat (3) @(posedge clk_48);
    #1 rst = 1'b0;

    // Reset values
    check("rst_spi_clk", 32'(spi_clk), 32'd1);
    check("rst_spi_mosi", 32'(spi_mosi), 32'd1);
    check("rst_spi_cs", 32'(spi_cs), 32'd1);
    check("rst_io_ready", 32'(bus.io_ready), 32'd0);
    check("rst_read_data", bus.io_read_data, 32'd0);

    // io_ready: unselected strobe gives nothing, selected read gives one pulse
    @(posedge clk_48); #1;
    bus.io_sel = 1'b0; bus.io_addr_strobe = 1'b1; bus.io_read_strobe = 1'b1; bus.io_addr = ADDR_CTRL;
    @(posedge clk_48); #1;
    bus.io_addr_strobe = 1'b0; bus.io_read_strobe = 1'b0;
    check("ready_unselected", 32'(bus.io_ready), 32'd0);
    bus.io_sel = 1'b1; bus.io_addr_strobe = 1'b1; bus.io_read_strobe = 1'b1;
    @(posedge clk_48); #1;
    bus.io_sel = 1'b0; bus.io_addr_strobe = 1'b0; bus.io_read_strobe = 1'b0;
    check("ready_pulse", 32'(bus.io_ready), 32'd1);
    check("ctrl_after_reset", bus.io_read_data, 32'h1 | RXE);
    @(posedge clk_48); #1;
    check("ready_one_cycle", 32'(bus.io_ready), 32'd0);

    // Single-byte transfers from the vector table
    for (int i = 0; i < 5; i++) begin
      miso_hi = vecs[i].miso_hi;
      bus_write(ADDR_DIV, 32'(vecs[i].div));
      clear_mon();
      bus_write(ADDR_DATA, 32'(vecs[i].tx));
      t0 = last_wr_cyc;
      wait_idle("vec_idle");
      check("vec_rises", rise_q.size(), 32'd8);
      check("vec_falls", fall_q.size(), 32'd8);
      if (fall_q.size() == 8) check("vec_first_fall", fall_q[0] - t0, 32'd2);
      if (rise_q.size() == 8) begin
        for (int j = 0; j < 7; j++)
          check("vec_period", rise_q[j+1] - rise_q[j], vecs[i].period);
        mb = '0;
        for (int j = 0; j < 8; j++) mb = {mb[6:0], mosi_q[j]};
        check("vec_mosi", 32'(mb), 32'(vecs[i].tx));
      end
      bus_read(ADDR_DATA, r);
      check("vec_rx", r, 32'(vecs[i].exp_rx));
    end

    // Back-to-back bytes at DIV=3: no gap across byte boundaries
    miso_hi = 1'b0;
    bus_write(ADDR_DIV, 32'd3);
    clear_mon();
    bus_write(ADDR_DATA, 32'h12);
    bus_write(ADDR_DATA, 32'h34);
    bus_write(ADDR_DATA, 32'h56);
    bus_read(ADDR_CTRL, r);
    check("b2b_busy", 32'(r[CTRL_BUSY]), 32'd1);
    wait_idle("b2b_idle");
    check("b2b_rises", rise_q.size(), 32'd24);
    if (rise_q.size() == 24)
      for (int j = 0; j < 23; j++)
        check("b2b_period", rise_q[j+1] - rise_q[j], 32'd8);
`ifdef SPI_MASTER_RX_FIFO_EN
    bus_read(ADDR_CTRL, r);
    check("b2b_rx_count", 32'(r[15:12]), 32'd3);
    bus_read(ADDR_DATA, r); check("b2b_rx0", r, 32'h12);
    bus_read(ADDR_DATA, r); check("b2b_rx1", r, 32'h34);
    bus_read(ADDR_DATA, r); check("b2b_rx2", r, 32'h56);
    bus_read(ADDR_DATA, r); check("b2b_rx_empty_read", r, 32'h0);
`else
    bus_read(ADDR_DATA, r); check("b2b_hold", r, 32'h56);
`endif

    // RX side with miso tied high
    miso_hi = 1'b1;
    bus_write(ADDR_DIV, 32'd0);
    clear_mon();
`ifdef SPI_MASTER_RX_FIFO_EN
    for (int k = 0; k < 8; k++) bus_write(ADDR_DATA, 32'(k));
    repeat (40) @(posedge clk_48);
    bus_write(ADDR_DATA, 32'h08);
    bus_write(ADDR_DATA, 32'h09);
    repeat (300) @(posedge clk_48);
    check("stall_rises", rise_q.size(), 32'd64);
    bus_read(ADDR_CTRL, r);
    check("stall_ctrl", r, 32'h0000_8203);
    repeat (50) @(posedge clk_48);
    check("stall_holds", rise_q.size(), 32'd64);
    bus_read(ADDR_DATA, r);
    check("stall_read", r, 32'hFF);
    repeat (40) @(posedge clk_48);
    check("release_rises", rise_q.size(), 32'd72);
    bus_read(ADDR_CTRL, r);
    check("release_ctrl", r, 32'h0000_8103);
`else
    bus_write(ADDR_DATA, 32'h00);
    bus_write(ADDR_DATA, 32'h00);
    wait_idle("hold_idle");
    check("hold_rises", rise_q.size(), 32'd16);
    bus_read(ADDR_CTRL, r);
    check("hold_ctrl", r, 32'h0000_0001);
    bus_read(ADDR_DATA, r); check("hold_read0", r, 32'hFF);
    bus_read(ADDR_DATA, r); check("hold_read1", r, 32'hFF);
`endif

    // Clean slate for the overflow test
    @(posedge clk_48); #1 rst = 1'b1;
    @(posedge clk_48); #1 rst = 1'b0;
    miso_hi = 1'b0;

    // Overflow at DIV=255, then reset mid-byte
    bus_write(ADDR_DIV, 32'd255);
    bus_read(ADDR_DIV, r);
    check("div_readback", r, 32'hFF);
    bus_write(2'd3, 32'hDEAD_BEEF);
    bus_read(2'd3, r);
    check("offset3_read", r, 32'h0);
    for (int k = 0; k < 10; k++) bus_write(ADDR_DATA, 32'(k * 8'h11));
    bus_read(ADDR_CTRL, r);
    check("ovf_ctrl", r, 32'h0000_0817 | RXE);
    bus_write(ADDR_CTRL, 32'h11);
    bus_read(ADDR_CTRL, r);
    check("ovf_cleared", r, 32'h0000_0807 | RXE);
    bus_write(ADDR_CTRL, 32'h00);
    check("cs_low_while_busy", 32'(spi_cs), 32'd0);
    check("mid_byte_clk_low", 32'(spi_clk), 32'd0);
    check("mid_byte_mosi", 32'(spi_mosi), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_clk", 32'(spi_clk), 32'd1);
    check("async_rst_cs", 32'(spi_cs), 32'd1);
    check("async_rst_mosi", 32'(spi_mosi), 32'd1);
    repeat (2) @(posedge clk_48);
    #1 rst = 1'b0;
    clear_mon();
    repeat (300) @(posedge clk_48);
    check("post_rst_rises", rise_q.size(), 32'd0);
    check("post_rst_falls", fall_q.size(), 32'd0);
    bus_read(ADDR_CTRL, r);
    check("post_rst_ctrl", r, 32'h1 | RXE);
    bus_read(ADDR_DIV, r);
    check("post_rst_div", r, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
